// File: rtl/router_pkg.sv
// Shared constants and types for the router output FIFO slice.
// Optional timeout flush is enabled by defining ROUTER_FIFO_TIMEOUT_EN.
package router_pkg;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 30;

    // Header byte: payload length in the upper six bits, destination in the lower two.
    typedef struct packed {
        logic [5:0] len;
        logic [1:0] addr;
    } hdr_t;

    typedef struct packed {
        logic       hdr;
        logic [7:0] data;
    } fifo_word_t;

    // Reads still owed after a header: every payload byte plus the parity byte.
    function automatic logic [5:0] pkt_reads(input logic [5:0] len);
        return len + 6'd1;
    endfunction

endpackage

// File: rtl/router_out_fifo_if.sv
// Core-write / destination-read bundle of one router output FIFO.
// The FIFO takes the slave side; the core and destination take the master side.
interface router_out_fifo_if #(
    parameter int DATA_W = router_pkg::DATA_W
);
    logic              write_enb;
    logic              lfd_state;
    logic [DATA_W-1:0] data_in;
    logic              full;
    logic              empty;
    logic              read_enb;
    logic [DATA_W-1:0] dout;
    logic              valid_out;
    logic              pkt_active;
    logic              soft_reset;

    modport master (
        output write_enb, lfd_state, data_in, read_enb,
        input  full, empty, dout, valid_out, pkt_active, soft_reset
    );

    modport slave (
        input  write_enb, lfd_state, data_in, read_enb,
        output full, empty, dout, valid_out, pkt_active, soft_reset
    );
endinterface

// File: rtl/router_fifo_timer.sv
// Idle-destination timer: pulses soft_reset once data has waited TIMEOUT cycles unread.
// Only built when ROUTER_FIFO_TIMEOUT_EN is defined.
`ifdef ROUTER_FIFO_TIMEOUT_EN
module router_fifo_timer #(
    parameter int TIMEOUT = router_pkg::TIMEOUT
) (
    input  logic clk,
    input  logic rstn,
    input  logic empty,
    input  logic read_enb,
    output logic soft_reset
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] idle_cnt;

    // Decoded from the registered count so the pulse is glitch-free and lasts one cycle.
    assign soft_reset = (idle_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idle_cnt <= '0;
        end else if (soft_reset || empty || read_enb) begin
            // read_enb with data present is always an accepted read
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

endmodule
`endif

// File: rtl/router_out_fifo.sv
// Per-destination output FIFO of the 1x3 router with header marker and packet tracking.
// Define ROUTER_FIFO_TIMEOUT_EN to add the idle-destination timeout flush.
module router_out_fifo
    import router_pkg::*;
#(
    parameter int DATA_W = router_pkg::DATA_W,
    parameter int DEPTH  = router_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rstn,
    router_out_fifo_if.slave  fifo
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W:0]   mem [DEPTH];
    logic [DATA_W:0]   rd_word;
    logic [DATA_W-1:0] dout_q;
    logic [5:0]        pkt_cnt;
    logic              pkt_active_q;
    logic              full;
    logic              empty;
    logic              flush;
    logic              wr_ok;
    logic              rd_ok;

    // Extra pointer MSB tells a full ring from an empty one.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // Flush wins over both a read and a write in the same cycle.
    assign wr_ok = fifo.write_enb && !full  && !flush;
    assign rd_ok = fifo.read_enb  && !empty && !flush;

`ifdef ROUTER_FIFO_TIMEOUT_EN
    router_fifo_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk        (clk),
        .rstn       (rstn),
        .empty      (empty),
        .read_enb   (fifo.read_enb),
        .soft_reset (flush)
    );
`else
    assign flush = 1'b0;
`endif

    assign rd_word = mem[rd_ptr[AW-1:0]];

    // NOTE: storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= {fifo.lfd_state, fifo.data_in};
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout_q <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout_q <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                dout_q <= rd_word[DATA_W-1:0];
            end
        end
    end

    // A marked read (re)loads the remaining-read count, so a header mid-packet resyncs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pkt_cnt      <= '0;
            pkt_active_q <= 1'b0;
        end else if (flush) begin
            pkt_cnt      <= '0;
            pkt_active_q <= 1'b0;
        end else if (rd_ok) begin
            if (rd_word[DATA_W]) begin
                pkt_cnt      <= pkt_reads(rd_word[7:2]);
                pkt_active_q <= 1'b1;
            end else if (pkt_active_q) begin
                pkt_cnt <= pkt_cnt - 6'd1;
                if (pkt_cnt == 6'd1) begin
                    pkt_active_q <= 1'b0;
                end
            end
        end
    end

    assign fifo.full       = full;
    assign fifo.empty      = empty;
    assign fifo.valid_out  = !empty;
    assign fifo.dout       = dout_q;
    assign fifo.pkt_active = pkt_active_q;
    assign fifo.soft_reset = flush;

endmodule

// File: tb/tb_router_out_fifo.sv
// Self-checking bench for router_out_fifo: queue-based reference model plus directed and random traffic.
// Build with ROUTER_FIFO_TIMEOUT_EN defined to exercise the timeout flush.
module tb_router_out_fifo;
    import router_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    router_out_fifo_if #(.DATA_W(DATA_W)) bus();

    router_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .fifo (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, plus what the reader should have seen.
    fifo_word_t q[$];
    logic [7:0] m_dout;
    bit         m_active;
    int         m_rem;
    int         m_idle;
    bit         cmp_en = 1'b0;

    function automatic bit m_soft();
`ifdef ROUTER_FIFO_TIMEOUT_EN
        return m_idle == TIMEOUT - 1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_dout   = '0;
        m_active = 1'b0;
        m_rem    = 0;
        m_idle   = 0;
    endtask

    task automatic model_step(input bit we, input bit lfd, input logic [7:0] din, input bit re);
        bit flush, rd, wr, was_empty;
        fifo_word_t w;
        flush     = m_soft();
        was_empty = (q.size() == 0);
        rd        = re && !was_empty;
        wr        = we && (q.size() < DEPTH);
        if (flush) begin
            model_reset();
            return;
        end
        if (rd) begin
            w      = q.pop_front();
            m_dout = w.data;
            if (w.hdr) begin
                m_rem    = int'(w.data[7:2]) + 1;
                m_active = 1'b1;
            end else if (m_active) begin
                m_rem--;
                if (m_rem == 0) m_active = 1'b0;
            end
        end
        if (wr) q.push_back('{hdr: lfd, data: din});
        if (was_empty || rd) m_idle = 0;
        else                 m_idle++;
    endtask

    always @(negedge clk) begin
        if (cmp_en && rstn) begin
            check("full",       bus.full,       q.size() == DEPTH);
            check("empty",      bus.empty,      q.size() == 0);
            check("valid_out",  bus.valid_out,  q.size() != 0);
            check("dout",       bus.dout,       m_dout);
            check("pkt_active", bus.pkt_active, m_active);
            check("soft_reset", bus.soft_reset, m_soft());
        end
    end

    // One clock of stimulus; called at a negedge, returns at the next negedge.
    task automatic cycle(input bit we, input bit lfd, input logic [7:0] din, input bit re);
        bus.write_enb = we;
        bus.lfd_state = lfd;
        bus.data_in   = din;
        bus.read_enb  = re;
        @(posedge clk);
        model_step(we, lfd, din, re);
        @(negedge clk);
    endtask

    task automatic do_reset();
        cmp_en        = 1'b0;
        bus.write_enb = 1'b0;
        bus.lfd_state = 1'b0;
        bus.data_in   = '0;
        bus.read_enb  = 1'b0;
        #2 rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        cmp_en = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pkt [5];
        int first_pulse;
        int pulses;
        int re_pct;
        bit lfd;
        logic [7:0] din;
        hdr_t h;

        pkt[0] = 8'h0D; pkt[1] = 8'hA1; pkt[2] = 8'hB2; pkt[3] = 8'hC3; pkt[4] = 8'h5E;
        bus.write_enb = 1'b0;
        bus.lfd_state = 1'b0;
        bus.data_in   = '0;
        bus.read_enb  = 1'b0;

        // Power-on reset values
        #2;
        check("rst_empty",      bus.empty,      1);
        check("rst_full",       bus.full,       0);
        check("rst_valid",      bus.valid_out,  0);
        check("rst_dout",       bus.dout,       0);
        check("rst_pkt_active", bus.pkt_active, 0);
        check("rst_soft_reset", bus.soft_reset, 0);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        cmp_en = 1'b1;

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h11 + 8'(i), 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("pre_rst_dout", bus.dout, 8'h11);
        cmp_en = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("async_empty", bus.empty,     1);
        check("async_valid", bus.valid_out, 0);
        check("async_dout",  bus.dout,      0);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        cmp_en = 1'b1;

        // One packet: header len 3 addr 1, three payload bytes, parity
        for (int i = 0; i < 5; i++) cycle(1'b1, i == 0, pkt[i], 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            check("pkt_dout",   bus.dout,       pkt[i]);
            check("pkt_active", bus.pkt_active, i < 4);
        end
        check("pkt_drained", bus.empty, 1);

        // Fill to full, drop an extra write, drain in order
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'(3 * i + 1), 1'b0);
        check("fill_full", bus.full, 1);
        cycle(1'b1, 1'b0, 8'hFF, 1'b0);
        check("drop_full", bus.full, 1);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            check("fill_order", bus.dout, 8'(3 * i + 1));
        end
        check("fill_empty", bus.empty, 1);

        // Steady read+write at half full
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'h40 + 8'(i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 8'h80 + 8'(i), 1'b1);
            check("rw_dout", bus.dout, (i < 8) ? 8'h40 + 8'(i) : 8'h80 + 8'(i - 8));
        end
        check("rw_full",  bus.full,  0);
        check("rw_empty", bus.empty, 0);
        check("rw_count", q.size(),  8);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("rw_last", bus.dout, 8'h89);

        // Full with simultaneous read and write: write is dropped
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'h20 + 8'(i), 1'b0);
        cycle(1'b1, 1'b0, 8'hEE, 1'b1);
        check("fullrw_dout", bus.dout,  8'h20);
        check("fullrw_full", bus.full,  0);
        check("fullrw_cnt",  q.size(),  15);
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("fullrw_last",  bus.dout,  8'h2F);
        check("fullrw_empty", bus.empty, 1);

        // Idle destination
        do_reset();
`ifdef ROUTER_FIFO_TIMEOUT_EN
        cycle(1'b1, 1'b0, 8'h31, 1'b0);
        first_pulse = -1;
        for (int j = 1; j <= 35; j++) begin
            if (bus.soft_reset && first_pulse < 0) first_pulse = j;
            cycle(j == 1, 1'b0, 8'h32, 1'b0);
        end
        check("timeout_cycle", first_pulse, 30);
        check("timeout_empty", bus.empty,   1);
        cycle(1'b1, 1'b0, 8'h41, 1'b0);
        pulses = 0;
        for (int j = 1; j <= 58; j++) begin
            if (bus.soft_reset) pulses++;
            cycle(j == 1, 1'b0, 8'h42, j == 29);
        end
        check("timeout_restart", pulses, 0);
        check("restart_dout",    bus.dout, 8'h41);
`else
        cycle(1'b1, 1'b0, 8'h31, 1'b0);
        cycle(1'b1, 1'b0, 8'h32, 1'b0);
        pulses = 0;
        for (int j = 0; j < 100; j++) begin
            if (bus.soft_reset) pulses++;
            cycle(1'b0, 1'b0, 8'h00, 1'b0);
        end
        check("no_timeout",  pulses,        0);
        check("data_waits",  bus.valid_out, 1);
`endif

        // Random traffic with varying reader pressure
        do_reset();
        for (int seg = 0; seg < 8; seg++) begin
            case (seg % 4)
                0:       re_pct = 55;
                1:       re_pct = 20;
                2:       re_pct = 90;
                default: re_pct = 3;
            endcase
            for (int i = 0; i < 100; i++) begin
                lfd = ($urandom_range(0, 5) == 0);
                if (lfd) begin
                    h.len  = 6'($urandom_range(1, 62));
                    h.addr = 2'($urandom_range(0, 2));
                    din    = h;
                end else begin
                    din = 8'($urandom);
                end
                cycle($urandom_range(0, 99) < 60, lfd, din, $urandom_range(0, 99) < re_pct);
            end
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
